// File: rtl/wb_regfile.sv
// wb_regfile: write-back stage and general-purpose register file.
//   Accepts the EX result {wd_i, wreg_i, wdata_i}, holds it for one cycle in
//   a write-back register and then commits it to the register array.
//   Register 0 always reads as zero. Two combinational read ports forward
//   from the in-flight EX result first, then from the write-back register,
//   and only then read the array.
// Ports:
//   Clk                          system clock, rising edge
//   Rst_n                        synchronous reset, active HIGH despite the name
//   wd_i / wreg_i / wdata_i      EX result: destination, write request, data
//   stall_i                      hold the write-back register (no capture, no commit)
//   flush_i                      discard the incoming EX result
//   re1_i / raddr1_i / rdata1_o  read port 1
//   re2_i / raddr2_i / rdata2_o  read port 2
//   wb_wd_o / wb_wreg_o / wb_wdata_o  write-back register contents
module wb_regfile #(
  parameter int unsigned REG_NUM = 32,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned DW      = 32
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [REG_AW-1:0] wd_i,
  input  logic              wreg_i,
  input  logic [DW-1:0]     wdata_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              re1_i,
  input  logic [REG_AW-1:0] raddr1_i,
  output logic [DW-1:0]     rdata1_o,
  input  logic              re2_i,
  input  logic [REG_AW-1:0] raddr2_i,
  output logic [DW-1:0]     rdata2_o,
  output logic [REG_AW-1:0] wb_wd_o,
  output logic              wb_wreg_o,
  output logic [DW-1:0]     wb_wdata_o
);

  logic [DW-1:0] regs [REG_NUM];

  // Reset wins over everything, so a pending write-back entry is dropped
  // rather than committed when reset arrives mid-operation.
  always_ff @(posedge Clk) begin
    if (Rst_n) begin
      for (int unsigned i = 0; i < REG_NUM; i++) begin
        regs[i] <= '0;
      end
      wb_wd_o    <= '0;
      wb_wreg_o  <= 1'b0;
      wb_wdata_o <= '0;
    end else if (!stall_i) begin
      if (wb_wreg_o && (wb_wd_o != '0)) begin
        regs[wb_wd_o] <= wb_wdata_o;
      end
      if (flush_i) begin
        wb_wd_o    <= '0;
        wb_wreg_o  <= 1'b0;
        wb_wdata_o <= '0;
      end else begin
        wb_wd_o    <= wd_i;
        wb_wreg_o  <= wreg_i;
        wb_wdata_o <= wdata_i;
      end
    end
  end

  // EX forwarding ignores stall_i: a stalled EX result is still the newest
  // value of its destination register.
  logic ex_fwd;
  assign ex_fwd = wreg_i && !flush_i;

  always_comb begin
    rdata1_o = '0;
    if (Rst_n || !re1_i || (raddr1_i == '0)) begin
      rdata1_o = '0;
    end else if (ex_fwd && (wd_i == raddr1_i)) begin
      rdata1_o = wdata_i;
    end else if (wb_wreg_o && (wb_wd_o == raddr1_i)) begin
      rdata1_o = wb_wdata_o;
    end else begin
      rdata1_o = regs[raddr1_i];
    end
  end

  always_comb begin
    rdata2_o = '0;
    if (Rst_n || !re2_i || (raddr2_i == '0)) begin
      rdata2_o = '0;
    end else if (ex_fwd && (wd_i == raddr2_i)) begin
      rdata2_o = wdata_i;
    end else if (wb_wreg_o && (wb_wd_o == raddr2_i)) begin
      rdata2_o = wb_wdata_o;
    end else begin
      rdata2_o = regs[raddr2_i];
    end
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Consumer end of the execute-stage result interface: accepts destination address, write-enable and result data from EX.
- Holds them for one cycle in an internal write-back register, then commits them into a 32x32 general-purpose register file.
- Provides two combinational read ports to the decode stage, with full forwarding from the in-flight EX result and from the write-back register, so decode never sees stale data.

Parameters:
- REG_NUM, 32, number of architectural registers (register 0 hardwired to zero)
- REG_AW, 5, register address width (log2 REG_NUM)
- DW, 32, data width

Ports:
- Clk input 1 system clock; all state updates on rising edge
- Rst_n input 1 reset, synchronous, active-high (asserted = 1 resets on the next rising edge of Clk)
- wd_i input REG_AW destination register address from EX
- wreg_i input 1 write request from EX
- wdata_i input DW result data from EX
- stall_i input 1 hold the write-back register (no capture, no commit)
- flush_i input 1 discard the incoming EX result this cycle
- re1_i input 1 read port 1 enable
- raddr1_i input REG_AW read port 1 address
- rdata1_o output DW read port 1 data (combinational)
- re2_i input 1 read port 2 enable
- raddr2_i input REG_AW read port 2 address
- rdata2_o output DW read port 2 data (combinational)
- wb_wd_o output REG_AW write-back register address (debug/hazard)
- wb_wreg_o output 1 write-back register valid
- wb_wdata_o output DW write-back register data

Behaviour:
- Reset (Rst_n=1 at rising edge):
  - All 32 array entries = 0.
  - wb_wreg_o=0, wb_wd_o=0, wb_wdata_o=0.
  - While Rst_n=1, rdata1_o=rdata2_o=0 combinationally.
- Capture (edge, Rst_n=0):
  - stall_i=1: WB register holds its value; no commit.
  - stall_i=0, flush_i=1: WB register loads wreg=0, wd=0, wdata=0; previous WB content still commits this edge.
  - stall_i=0, flush_i=0: WB register loads {wd_i, wreg_i, wdata_i}; previous WB content commits this edge.
  - stall_i and flush_i both 1: stall wins; WB register holds, no commit.
- Commit (edge, Rst_n=0, stall_i=0): if wb_wreg_o=1 and wb_wd_o!=0, then array[wb_wd_o] <= wb_wdata_o. Writes to register 0 are silently dropped.
- Latency: EX result presented at cycle N is captured at edge N, committed at edge N+1, and visible from the array from cycle N+2. It is visible via forwarding from cycle N.
- Read port k (same logic for 1 and 2), first match wins:
  1. Rst_n=1 -> 0
  2. re=0 -> 0
  3. raddr=0 -> 0
  4. wreg_i=1, flush_i=0, wd_i==raddr -> wdata_i
  5. wb_wreg_o=1, wb_wd_o==raddr -> wb_wdata_o
  6. otherwise -> array[raddr]
- Forwarding from the EX inputs is suppressed when flush_i=1. It is not suppressed by stall_i, because the EX result is still valid.
- Both read ports may address the same register, or the register being written, in the same cycle. Each port resolves independently.
- Reset asserted mid-operation: the pending WB entry is discarded, not committed.
- No X propagation: all read outputs are driven in every branch.

Test Plan:
- Reset: preload r5=0x1234 via a normal write, assert Rst_n=1 for one edge, read r5 -> rdata1_o=0, wb_wreg_o=0.
- Write/commit: wd_i=3, wreg_i=1, wdata_i=0xDEADBEEF at cycle 0, then wreg_i=0. Read r3 via port 2:
  - cycle 0 -> 0xDEADBEEF (EX forward)
  - cycle 1 -> 0xDEADBEEF (WB forward)
  - cycle 2 -> 0xDEADBEEF (array)
- Priority: WB holds r7=0x11, EX presents r7=0x22 -> read r7 gives 0x22. After two more edges with wreg_i=0, r7 reads 0x22.
- r0: write wd_i=0, wdata_i=0xFFFFFFFF -> reads of r0 return 0 on both ports in every cycle.
- Stall: capture r9=0xAA, hold stall_i=1 for 3 cycles:
  - wb_wreg_o stays 1
  - array r9 not updated (check with wb forward masked by presenting wd_i=9, wdata_i=0xBB, which reads 0xBB)
  - release stall -> r9 commits 0xAA, then 0xBB captured.
- Flush: wd_i=4, wreg_i=1, wdata_i=0x55, flush_i=1 -> read r4 gives the old value (0). Next cycle wb_wreg_o=0, and r4 is never written.
